ft245_device: RTL and testbench

- FT245-style asynchronous-FIFO device endpoint: the chip side of the parallel UART bus, serving the master that drives rd/wr and watches rxf/txe.
- Lets a second FPGA image, or a simulation loopback, stand in for the USB FIFO chip.
- Bytes entering on the stream-in side are offered to the bus master via rxf/rd.
- Bytes the master writes via txe/wr leave on the stream-out side.

---
 rtl/ft245_device.sv | 181 ++++++++++++++++++
 tb/tb_ft245_device.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft245_device.sv
// FT245-style FIFO device endpoint: plays the USB FIFO chip for a bus master
// driving rd/wr strobes, with stream-side RX (toward master) and TX (from master) FIFOs.
module ft245_device #(
    parameter int DEPTH     = 16,
    parameter int PRECHARGE = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ft_rd_n,
    input  logic                     ft_wr_n,
    input  logic [7:0]               ft_din,
    output logic [7:0]               ft_dout,
    output logic                     ft_dout_oe,
    output logic                     ft_rxf_n,
    output logic                     ft_txe_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic [$clog2(DEPTH):0]   rx_level,
    output logic [$clog2(DEPTH):0]   tx_level,
    output logic                     proto_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = (PRECHARGE > 1) ? $clog2(PRECHARGE) : 1;
    localparam logic [PW-1:0] PRE_LOAD = PW'(PRECHARGE - 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {R_IDLE, R_ACTIVE, R_PRE} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ACTIVE, W_PRE} wr_state_t;

    rd_state_t r_state, r_next;
    wr_state_t w_state, w_next;

    logic          rd_q, wr_q, rd_arm, wr_arm;
    logic          rd_fall, rd_rise, wr_fall, wr_rise;
    logic          rd_ok, wr_ok, err_now;
    logic [PW-1:0] r_cnt, w_cnt;

    logic [7:0]    rx_mem [DEPTH];
    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr;
    logic [AW:0]   rx_count, tx_count, rx_count_next, tx_count_next;
    logic          rx_empty, tx_full;
    logic          rx_push, rx_pop, tx_push, tx_pop;

    // The arm flags suppress a falling edge for a strobe held low through reset release.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q   <= 1'b1;
            wr_q   <= 1'b1;
            rd_arm <= 1'b0;
            wr_arm <= 1'b0;
        end else begin
            rd_q <= ft_rd_n;
            wr_q <= ft_wr_n;
            if (ft_rd_n) rd_arm <= 1'b1;
            if (ft_wr_n) wr_arm <= 1'b1;
        end
    end

    assign rd_fall = rd_arm & rd_q & ~ft_rd_n;
    assign wr_fall = wr_arm & wr_q & ~ft_wr_n;
    assign rd_rise = ~rd_q & ft_rd_n;
    assign wr_rise = ~wr_q & ft_wr_n;

    assign rx_empty = (rx_count == '0);
    assign tx_full  = (tx_count == FULL_CNT);

    // Simultaneous falls and cross-direction contention reject both strobes.
    assign rd_ok   = rd_fall && (r_state == R_IDLE) && !rx_empty
                     && (w_state != W_ACTIVE) && !wr_fall;
    assign wr_ok   = wr_fall && (w_state == W_IDLE) && !tx_full
                     && (r_state != R_ACTIVE) && !rd_fall;
    assign err_now = (rd_fall && !rd_ok) || (wr_fall && !wr_ok);

    always_comb begin
        r_next = r_state;
        rx_pop = 1'b0;
        case (r_state)
            R_IDLE:   if (rd_ok) r_next = R_ACTIVE;
            R_ACTIVE: if (rd_rise) begin
                          rx_pop = 1'b1;
                          r_next = R_PRE;
                      end
            R_PRE:    if (r_cnt == '0) r_next = R_IDLE;
            default:  r_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_next  = w_state;
        tx_push = 1'b0;
        case (w_state)
            W_IDLE:   if (wr_ok) begin
                          tx_push = 1'b1;
                          w_next  = W_ACTIVE;
                      end
            W_ACTIVE: if (wr_rise) w_next = W_PRE;
            W_PRE:    if (w_cnt == '0) w_next = W_IDLE;
            default:  w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= R_IDLE;
            w_state    <= W_IDLE;
            r_cnt      <= '0;
            w_cnt      <= '0;
            ft_dout    <= '0;
            ft_dout_oe <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            r_state   <= r_next;
            w_state   <= w_next;
            proto_err <= err_now;
            if (r_state == R_ACTIVE && r_next == R_PRE) r_cnt <= PRE_LOAD;
            else if (r_state == R_PRE && r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
            if (w_state == W_ACTIVE && w_next == W_PRE) w_cnt <= PRE_LOAD;
            else if (w_state == W_PRE && w_cnt != '0)   w_cnt <= w_cnt - 1'b1;
            if (rd_ok) begin
                ft_dout    <= rx_mem[rx_rd_ptr];
                ft_dout_oe <= 1'b1;
            end else if (rx_pop) begin
                ft_dout_oe <= 1'b0;
            end
        end
    end

    assign ft_rxf_n = reset | (r_state != R_IDLE) | rx_empty;
    assign ft_txe_n = reset | (w_state != W_IDLE) | tx_full;

    assign rx_push = in_valid & in_ready;
    assign tx_pop  = out_valid & out_ready;

    always_comb begin
        rx_count_next = rx_count;
        tx_count_next = tx_count;
        if (rx_push && !rx_pop) rx_count_next = rx_count + 1'b1;
        if (!rx_push && rx_pop) rx_count_next = rx_count - 1'b1;
        if (tx_push && !tx_pop) tx_count_next = tx_count + 1'b1;
        if (!tx_push && tx_pop) tx_count_next = tx_count - 1'b1;
    end

    // Ready/valid flags are registered from the next occupancy so they never lag a push or pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            rx_count  <= '0;
            tx_count  <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
            rx_count  <= rx_count_next;
            tx_count  <= tx_count_next;
            in_ready  <= (rx_count_next != FULL_CNT);
            out_valid <= (tx_count_next != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= in_data;
        if (tx_push) tx_mem[tx_wr_ptr] <= ft_din;
    end

    assign out_data = tx_mem[tx_rd_ptr];
    assign rx_level = rx_count;
    assign tx_level = tx_count;

endmodule

// File: tb/tb_ft245_device.sv
// Directed bench for ft245_device: expected bytes are queued at stimulus time and
// popped by monitors whenever the device presents a byte on either side.
module tb_ft245_device;

    localparam int DEPTH     = 16;
    localparam int PRECHARGE = 2;
    localparam int LW        = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          ft_rd_n, ft_wr_n;
    logic [7:0]    ft_din, ft_dout;
    logic          ft_dout_oe, ft_rxf_n, ft_txe_n;
    logic          in_valid, in_ready;
    logic [7:0]    in_data;
    logic          out_valid, out_ready;
    logic [7:0]    out_data;
    logic [LW-1:0] rx_level, tx_level;
    logic          proto_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_rd[$];
    logic [7:0] exp_out[$];
    logic [7:0] mon_out_exp, mon_rd_exp, mon_hold;
    logic       mon_prev_oe = 1'b0;

    ft245_device #(.DEPTH(DEPTH), .PRECHARGE(PRECHARGE)) dut (
        .clk        (clk),
        .reset      (reset),
        .ft_rd_n    (ft_rd_n),
        .ft_wr_n    (ft_wr_n),
        .ft_din     (ft_din),
        .ft_dout    (ft_dout),
        .ft_dout_oe (ft_dout_oe),
        .ft_rxf_n   (ft_rxf_n),
        .ft_txe_n   (ft_txe_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .rx_level   (rx_level),
        .tx_level   (tx_level),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [7:0] d);
        ft_din  = d;
        ft_wr_n = 1'b0;
        exp_out.push_back(d);
        step();
        ft_wr_n = 1'b1;
        step(3);
    endtask

    task automatic busRead();
        ft_rd_n = 1'b0;
        step(2);
        ft_rd_n = 1'b1;
        step(3);
    endtask

    // Stream-out monitor: every accepted TX byte must match the next queued write.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_out.size() == 0) begin
                errors++;
                $display("[TB] FAIL out_unexpected: actual %0h required none", out_data);
            end else begin
                mon_out_exp = exp_out.pop_front();
                if (out_data !== mon_out_exp) begin
                    errors++;
                    $display("[TB] FAIL out_data: actual %0h required %0h", out_data, mon_out_exp);
                end
            end
        end
    end

    // Bus-read monitor: a new read presents the next queued RX byte and holds it stable.
    always @(negedge clk) begin
        if (ft_dout_oe === 1'b1 && !mon_prev_oe) begin
            checks++;
            if (exp_rd.size() == 0) begin
                errors++;
                $display("[TB] FAIL rd_unexpected: actual %0h required none", ft_dout);
            end else begin
                mon_rd_exp = exp_rd.pop_front();
                if (ft_dout !== mon_rd_exp) begin
                    errors++;
                    $display("[TB] FAIL rd_data: actual %0h required %0h", ft_dout, mon_rd_exp);
                end
            end
            mon_hold = ft_dout;
        end else if (ft_dout_oe === 1'b1 && mon_prev_oe) begin
            checks++;
            if (ft_dout !== mon_hold) begin
                errors++;
                $display("[TB] FAIL rd_stable: actual %0h required %0h", ft_dout, mon_hold);
            end
        end
        mon_prev_oe = (ft_dout_oe === 1'b1);
    end

    task automatic applyStimulus();
        reset = 1'b1; ft_rd_n = 1'b1; ft_wr_n = 1'b1; ft_din = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        step(2);
        checkOutput("rst_rxf_n", ft_rxf_n, 1);
        checkOutput("rst_txe_n", ft_txe_n, 1);
        checkOutput("rst_oe", ft_dout_oe, 0);
        checkOutput("rst_dout", ft_dout, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_rx_level", rx_level, 0);
        checkOutput("rst_tx_level", tx_level, 0);
        checkOutput("rst_proto_err", proto_err, 0);
        reset = 1'b0;
        checkOutput("post_rst_in_ready", in_ready, 0);
        step();
        checkOutput("idle_in_ready", in_ready, 1);
        checkOutput("idle_txe_n", ft_txe_n, 0);
        checkOutput("idle_rxf_n", ft_rxf_n, 1);

        $display("[TB] single read of 0xA5");
        in_data = 8'hA5; in_valid = 1'b1; exp_rd.push_back(8'hA5);
        step();
        in_valid = 1'b0;
        checkOutput("a5_rx_level", rx_level, 1);
        checkOutput("a5_rxf_n", ft_rxf_n, 0);
        ft_rd_n = 1'b0;
        step();
        checkOutput("a5_oe", ft_dout_oe, 1);
        checkOutput("a5_dout", ft_dout, 8'hA5);
        checkOutput("a5_rxf_busy", ft_rxf_n, 1);
        step(2);
        checkOutput("a5_oe_hold", ft_dout_oe, 1);
        ft_rd_n = 1'b1;
        step();
        checkOutput("a5_oe_off", ft_dout_oe, 0);
        checkOutput("a5_level_0", rx_level, 0);
        checkOutput("a5_pre1", ft_rxf_n, 1);
        step();
        checkOutput("a5_pre2", ft_rxf_n, 1);
        step();
        checkOutput("a5_empty_rxf", ft_rxf_n, 1);
        checkOutput("a5_no_err", proto_err, 0);

        $display("[TB] master writes 0x3C, 0xC3");
        ft_din = 8'h3C; ft_wr_n = 1'b0; exp_out.push_back(8'h3C);
        step();
        checkOutput("w1_tx_level", tx_level, 1);
        checkOutput("w1_txe_busy", ft_txe_n, 1);
        checkOutput("w1_out_valid", out_valid, 1);
        step();
        ft_wr_n = 1'b1;
        step();
        checkOutput("w1_pre_a", ft_txe_n, 1);
        step();
        checkOutput("w1_pre_b", ft_txe_n, 1);
        step();
        checkOutput("w1_txe_idle", ft_txe_n, 0);
        busWrite(8'hC3);
        checkOutput("w2_tx_level", tx_level, 2);
        out_ready = 1'b1;
        step();
        checkOutput("drain1_level", tx_level, 1);
        step();
        checkOutput("drain2_level", tx_level, 0);
        checkOutput("drain2_valid", out_valid, 0);
        out_ready = 1'b0;

        $display("[TB] fill TX then overflow");
        for (int i = 0; i < DEPTH; i++) busWrite(8'h10 + 8'(i));
        checkOutput("full_tx_level", tx_level, DEPTH);
        checkOutput("full_txe_n", ft_txe_n, 1);
        ft_din = 8'hFF; ft_wr_n = 1'b0;
        step();
        checkOutput("ovf_err", proto_err, 1);
        checkOutput("ovf_tx_level", tx_level, DEPTH);
        ft_wr_n = 1'b1;
        step();
        checkOutput("ovf_err_pulse", proto_err, 0);
        step(2);
        out_ready = 1'b1;
        step(DEPTH);
        out_ready = 1'b0;
        checkOutput("tx_drained", tx_level, 0);
        checkOutput("tx_drained_txe", ft_txe_n, 0);

        $display("[TB] simultaneous rd and wr falls");
        in_data = 8'h5A; in_valid = 1'b1; exp_rd.push_back(8'h5A);
        step();
        in_valid = 1'b0;
        ft_rd_n = 1'b0; ft_wr_n = 1'b0; ft_din = 8'h77;
        step();
        checkOutput("both_err", proto_err, 1);
        checkOutput("both_rx_level", rx_level, 1);
        checkOutput("both_tx_level", tx_level, 0);
        step();
        checkOutput("both_err_pulse", proto_err, 0);
        checkOutput("both_oe", ft_dout_oe, 0);
        ft_rd_n = 1'b1; ft_wr_n = 1'b1;
        step();
        checkOutput("both_oe_after", ft_dout_oe, 0);
        checkOutput("both_tx_after", tx_level, 0);

        $display("[TB] reset during an active read");
        for (int i = 0; i < 3; i++) begin
            in_data = 8'h61 + 8'(i); in_valid = 1'b1; exp_rd.push_back(in_data);
            step();
        end
        in_valid = 1'b0;
        checkOutput("mid_rx_level", rx_level, 4);
        ft_rd_n = 1'b0;
        step();
        checkOutput("mid_oe", ft_dout_oe, 1);
        reset = 1'b1;
        step();
        exp_rd.delete();
        checkOutput("mid_rst_level", rx_level, 0);
        checkOutput("mid_rst_oe", ft_dout_oe, 0);
        checkOutput("mid_rst_rxf", ft_rxf_n, 1);
        checkOutput("mid_rst_err", proto_err, 0);
        reset = 1'b0;
        checkOutput("mid_rel_rxf", ft_rxf_n, 1);
        step();
        checkOutput("held_rd_err1", proto_err, 0);
        step();
        checkOutput("held_rd_err2", proto_err, 0);
        checkOutput("held_rd_oe", ft_dout_oe, 0);
        checkOutput("held_rd_level", rx_level, 0);
        ft_rd_n = 1'b1;
        step(2);

        $display("[TB] full RX with push blocked during pop");
        for (int i = 0; i < DEPTH; i++) begin
            in_data = 8'h80 + 8'(i); in_valid = 1'b1; exp_rd.push_back(in_data);
            step();
        end
        in_data = 8'hEE;
        checkOutput("rx_full_level", rx_level, DEPTH);
        checkOutput("rx_full_ready", in_ready, 0);
        ft_rd_n = 1'b0;
        step();
        checkOutput("rx_full_oe", ft_dout_oe, 1);
        checkOutput("rx_full_nopush", rx_level, DEPTH);
        ft_rd_n = 1'b1;
        step();
        checkOutput("rx_pop_level", rx_level, DEPTH - 1);
        checkOutput("rx_pop_ready", in_ready, 1);
        in_valid = 1'b0;
        step(2);
        for (int i = 1; i < DEPTH; i++) busRead();
        checkOutput("rx_drained", rx_level, 0);
        checkOutput("rx_drained_rxf", ft_rxf_n, 1);

        step(2);
        checkOutput("sb_rd_drained", exp_rd.size(), 0);
        checkOutput("sb_out_drained", exp_out.size(), 0);
    endtask

    initial begin
        applyStimulus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: actual timeout required completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
